// File: rtl/hd_link_ctrl.sv
// Half-duplex single-wire link: frames TX words onto a shared line behind a pass gate, deserialises RX frames.
// Outputs registered (TX_READY comb); TX held off while busy or line low; RX has no backpressure.
module hd_link_ctrl #(
    parameter int WIDTH = 8,
    parameter int GUARD = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             FRAME_ERR,
    output logic             BUSY,
    input  logic             LINE_IN,
    output logic             LINE_OUT,
    output logic             EN,
    output logic             ENB
);

    localparam int MAXC = (WIDTH + 1 > GUARD - 1) ? WIDTH + 1 : GUARD - 1;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] C_STOP  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] C_GLAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [2:0] {
        LISTEN   = 3'd0,
        TURN_ON  = 3'd1,
        SEND     = 3'd2,
        TURN_OFF = 3'd3,
        RECV     = 3'd4
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx_sh;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_vld;
    logic             r_frame_err;
    logic             r_busy;
    logic             r_line_out;
    logic             r_en;
    logic             r_enb;

    logic             w_tx_ready;
    logic [WIDTH:0]   w_rx_cat;

    assign w_tx_ready = (r_state == LISTEN) && LINE_IN && RN;
    // Received bits arrive LSB first, so new bits enter at the MSB and shift down.
    assign w_rx_cat   = {LINE_IN, r_rx_sh};

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state     <= LISTEN;
            r_cnt       <= '0;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_rx_data   <= '0;
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_line_out  <= 1'b1;
            r_en        <= 1'b0;
            r_enb       <= 1'b1;
        end else begin
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                LISTEN: begin
                    if (!LINE_IN) begin
                        r_state <= RECV;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (TX_VALID && w_tx_ready) begin
                        r_state    <= TURN_ON;
                        r_cnt      <= '0;
                        r_tx_sh    <= TX_DATA;
                        r_busy     <= 1'b1;
                        r_en       <= 1'b1;
                        r_enb      <= 1'b0;
                        r_line_out <= 1'b1;
                    end
                end
                TURN_ON: begin
                    if (r_cnt == C_GLAST) begin
                        r_state    <= SEND;
                        r_cnt      <= '0;
                        r_line_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                SEND: begin
                    // r_cnt is the index of the bit currently on the line (0 = start).
                    if (r_cnt == C_STOP) begin
                        r_state    <= TURN_OFF;
                        r_cnt      <= '0;
                        r_en       <= 1'b0;
                        r_enb      <= 1'b1;
                        r_line_out <= 1'b1;
                    end else if (r_cnt == C_WIDTH) begin
                        r_line_out <= 1'b1;
                        r_cnt      <= r_cnt + C_ONE;
                    end else begin
                        r_line_out <= r_tx_sh[0];
                        r_tx_sh    <= r_tx_sh >> 1;
                        r_cnt      <= r_cnt + C_ONE;
                    end
                end
                TURN_OFF: begin
                    if (r_cnt == C_GLAST) begin
                        r_state <= LISTEN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                RECV: begin
                    if (r_cnt == C_WIDTH) begin
                        r_state <= LISTEN;
                        r_busy  <= 1'b0;
                        if (LINE_IN) begin
                            r_rx_data <= r_rx_sh;
                            r_rx_vld  <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_rx_sh <= w_rx_cat[WIDTH:1];
                        r_cnt   <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state    <= LISTEN;
                    r_busy     <= 1'b0;
                    r_en       <= 1'b0;
                    r_enb      <= 1'b1;
                    r_line_out <= 1'b1;
                end
            endcase
        end
    end

    assign TX_READY  = w_tx_ready;
    assign RX_DATA   = r_rx_data;
    assign RX_VALID  = r_rx_vld;
    assign FRAME_ERR = r_frame_err;
    assign BUSY      = r_busy;
    assign LINE_OUT  = r_line_out;
    assign EN        = r_en;
    assign ENB       = r_enb;

endmodule

// File: tb/tb_hd_link_ctrl.sv
// Directed bench for hd_link_ctrl (WIDTH=8, GUARD=2): TX framing, RX, frame error, priority, reset.
module tb_hd_link_ctrl;

    logic       CLK;
    logic       RN;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       BUSY;
    logic       LINE_IN;
    logic       LINE_OUT;
    logic       EN;
    logic       ENB;

    int checks;
    int failures;

    hd_link_ctrl #(.WIDTH(8), .GUARD(2)) dut (
        .CLK(CLK), .RN(RN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
        .BUSY(BUSY), .LINE_IN(LINE_IN), .LINE_OUT(LINE_OUT),
        .EN(EN), .ENB(ENB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, stop; returns 1ns after the edge that samples the stop bit.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input string name);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            LINE_IN = f[i];
            tick();
            if (i < 9) begin
                checks++;
                if (RX_VALID !== 1'b0 || FRAME_ERR !== 1'b0 || EN !== 1'b0 || TX_READY !== 1'b0 || BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_mid bit=%0d: rx_valid=%b frame_err=%b en=%b tx_ready=%b busy=%b, required 0 0 0 0 1",
                             name, i, RX_VALID, FRAME_ERR, EN, TX_READY, BUSY);
                end
            end
        end
    endtask

    task automatic test_reset();
        RN = 1'b0; LINE_IN = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'h00;
        tick();
        checks++;
        if (EN !== 1'b0 || ENB !== 1'b1 || LINE_OUT !== 1'b1) begin
            failures++;
            $display("FAIL reset_gate: en=%b enb=%b line_out=%b, required 0 1 1", EN, ENB, LINE_OUT);
        end
        checks++;
        if (RX_DATA !== 8'h00 || RX_VALID !== 1'b0 || FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_rx: rx_data=%h rx_valid=%b frame_err=%b busy=%b, required 00 0 0 0",
                     RX_DATA, RX_VALID, FRAME_ERR, BUSY);
        end
        checks++;
        if (TX_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx_ready: got %b, required 0", TX_READY);
        end
        TX_VALID = 1'b0;
        tick();
        RN = 1'b1;
        tick();
        checks++;
        if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: tx_ready=%b busy=%b, required 1 0", TX_READY, BUSY);
        end
    endtask

    task automatic test_tx_a5();
        logic [11:0] lo_pat;
        logic        exp_en, exp_lo, exp_rdy, exp_busy;
        lo_pat = 12'b1101_0010_1011;
        TX_DATA = 8'hA5; TX_VALID = 1'b1;
        checks++;
        if (TX_READY !== 1'b1) begin
            failures++;
            $display("FAIL tx_ready_before_accept: got %b, required 1", TX_READY);
        end
        tick();
        TX_VALID = 1'b0; TX_DATA = 8'h00;
        for (int n = 1; n <= 15; n++) begin
            exp_en   = (n <= 12);
            exp_lo   = (n <= 12) ? lo_pat[n-1] : 1'b1;
            exp_rdy  = (n >= 15);
            exp_busy = (n <= 14);
            checks++;
            if (EN !== exp_en || ENB !== ~exp_en || LINE_OUT !== exp_lo || TX_READY !== exp_rdy || BUSY !== exp_busy) begin
                failures++;
                $display("FAIL tx_a5 cycle=%0d: en=%b enb=%b line_out=%b tx_ready=%b busy=%b, required %b %b %b %b %b",
                         n, EN, ENB, LINE_OUT, TX_READY, BUSY, exp_en, ~exp_en, exp_lo, exp_rdy, exp_busy);
            end
            if (n < 15) tick();
        end
    endtask

    task automatic test_rx_good();
        rx_frame(8'h3C, 1'b1, "rx_3c");
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h3C || FRAME_ERR !== 1'b0) begin
            failures++;
            $display("FAIL rx_3c_done: rx_valid=%b rx_data=%h frame_err=%b, required 1 3c 0", RX_VALID, RX_DATA, FRAME_ERR);
        end
        LINE_IN = 1'b1;
        tick();
        checks++;
        if (RX_VALID !== 1'b0 || RX_DATA !== 8'h3C) begin
            failures++;
            $display("FAIL rx_3c_pulse_end: rx_valid=%b rx_data=%h, required 0 3c", RX_VALID, RX_DATA);
        end
    endtask

    task automatic test_frame_err();
        rx_frame(8'h5A, 1'b0, "rx_err");
        checks++;
        if (FRAME_ERR !== 1'b1 || RX_VALID !== 1'b0 || RX_DATA !== 8'h3C) begin
            failures++;
            $display("FAIL rx_err_done: frame_err=%b rx_valid=%b rx_data=%h, required 1 0 3c", FRAME_ERR, RX_VALID, RX_DATA);
        end
        LINE_IN = 1'b1;
        tick();
        checks++;
        if (FRAME_ERR !== 1'b0 || RX_DATA !== 8'h3C) begin
            failures++;
            $display("FAIL rx_err_pulse_end: frame_err=%b rx_data=%h, required 0 3c", FRAME_ERR, RX_DATA);
        end
    endtask

    task automatic test_rx_priority();
        logic [7:0] d;
        int         t;
        d = 8'h96;
        TX_DATA = d; TX_VALID = 1'b1; LINE_IN = 1'b0;
        #1;
        checks++;
        if (TX_READY !== 1'b0) begin
            failures++;
            $display("FAIL prio_ready_line_low: got %b, required 0", TX_READY);
        end
        rx_frame(8'h42, 1'b1, "prio_rx");
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h42 || TX_READY !== 1'b1 || EN !== 1'b0) begin
            failures++;
            $display("FAIL prio_rx_done: rx_valid=%b rx_data=%h tx_ready=%b en=%b, required 1 42 1 0",
                     RX_VALID, RX_DATA, TX_READY, EN);
        end
        tick();
        TX_VALID = 1'b0; TX_DATA = 8'hFF;
        checks++;
        if (EN !== 1'b1 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL prio_tx_accept: en=%b busy=%b, required 1 1", EN, BUSY);
        end
        tick();
        tick();
        checks++;
        if (LINE_OUT !== 1'b0) begin
            failures++;
            $display("FAIL prio_tx_start: line_out=%b, required 0", LINE_OUT);
        end
        for (int b = 0; b < 8; b++) begin
            tick();
            checks++;
            if (LINE_OUT !== d[b]) begin
                failures++;
                $display("FAIL prio_tx_bit%0d: line_out=%b, required %b", b, LINE_OUT, d[b]);
            end
        end
        tick();
        checks++;
        if (LINE_OUT !== 1'b1 || EN !== 1'b1) begin
            failures++;
            $display("FAIL prio_tx_stop: line_out=%b en=%b, required 1 1", LINE_OUT, EN);
        end
        t = 0;
        while (TX_READY !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        checks++;
        if (TX_READY !== 1'b1 || t != 3) begin
            failures++;
            $display("FAIL prio_tx_return: tx_ready=%b after %0d cycles, required 1 after 3", TX_READY, t);
        end
    endtask

    task automatic test_back_to_back();
        rx_frame(8'h01, 1'b1, "b2b_first");
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h01 || FRAME_ERR !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_done: rx_valid=%b rx_data=%h frame_err=%b, required 1 01 0", RX_VALID, RX_DATA, FRAME_ERR);
        end
        rx_frame(8'hFF, 1'b1, "b2b_second");
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'hFF || FRAME_ERR !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_done: rx_valid=%b rx_data=%h frame_err=%b, required 1 ff 0", RX_VALID, RX_DATA, FRAME_ERR);
        end
        LINE_IN = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_tx();
        TX_DATA = 8'h00; TX_VALID = 1'b1;
        tick();
        TX_VALID = 1'b0;
        for (int n = 1; n < 6; n++) tick();
        checks++;
        if (EN !== 1'b1 || LINE_OUT !== 1'b0) begin
            failures++;
            $display("FAIL mid_tx_cycle6: en=%b line_out=%b, required 1 0", EN, LINE_OUT);
        end
        #2;
        RN = 1'b0;
        #1;
        checks++;
        if (EN !== 1'b0 || ENB !== 1'b1 || LINE_OUT !== 1'b1 || BUSY !== 1'b0 || TX_READY !== 1'b0) begin
            failures++;
            $display("FAIL mid_tx_async_reset: en=%b enb=%b line_out=%b busy=%b tx_ready=%b, required 0 1 1 0 0",
                     EN, ENB, LINE_OUT, BUSY, TX_READY);
        end
        @(negedge CLK);
        RN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (EN !== 1'b0 || ENB !== 1'b1 || LINE_OUT !== 1'b1 || BUSY !== 1'b0) begin
                failures++;
                $display("FAIL mid_tx_after_release c=%0d: en=%b enb=%b line_out=%b busy=%b, required 0 1 1 0",
                         c, EN, ENB, LINE_OUT, BUSY);
            end
        end
        checks++;
        if (TX_READY !== 1'b1) begin
            failures++;
            $display("FAIL mid_tx_ready_after: got %b, required 1", TX_READY);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tx_a5();
        tick();
        test_rx_good();
        test_frame_err();
        test_rx_priority();
        tick();
        test_back_to_back();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
